project_select_ctrl: RTL and testbench

PROJECT_SELECT_CTRL -- requirements
Module: project_select_ctrl

---
 rtl/project_select_ctrl_if.sv | 22 ++
 rtl/project_select_ctrl.sv | 146 ++++++++++++++
 tb/tb_project_select_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/project_select_ctrl_if.sv
// Wishbone classic slave bus bundle for the project-select controller.
// The master modport drives requests; the slave modport returns ack and read data.
interface project_select_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/project_select_ctrl.sv
// Project select controller: Wishbone register window driving a one-hot project
// enable, with a guard interval of all-off cycles between any two projects.
module project_select_ctrl #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          NUM_PROJECTS  = 32,
    parameter logic [7:0]  DEFAULT_GUARD = 8'd4
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    project_select_ctrl_if.slave        wbs,
    output logic [31:0]                 active,
    output logic                        switch_irq
);
    typedef enum logic [1:0] {S_OFF, S_GUARD, S_ON} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cur_id_q, cur_id_d;
    logic [4:0]  pend_id_q, pend_id_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  guard_q;
    logic        err_q, err_d;
    logic [4:0]  ctrl_id_q;
    logic        ctrl_en_q;
    logic        ack_q;
    logic [31:0] rdata_q, rdata_mux;
    logic        sw_q, sw_d;

    logic        hit, acc, wr, ctrl_wr, guard_wr, wr_en, id_ok;
    logic [1:0]  offset;
    logic [4:0]  wr_id;
    logic [7:0]  guard_eff;
    logic        unused_bits;

    assign hit      = wbs.wbs_stb_i & wbs.wbs_cyc_i & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign offset   = wbs.wbs_adr_i[3:2];
    // A held strobe after ack must not be acked again on the following cycle.
    assign acc      = hit & ~ack_q;
    assign wr       = acc & wbs.wbs_we_i;
    assign ctrl_wr  = wr && (offset == 2'd0) && (wbs.wbs_sel_i[0] | wbs.wbs_sel_i[1]);
    assign guard_wr = wr && (offset == 2'd2) && wbs.wbs_sel_i[0];

    // Unselected CTRL byte lanes keep their stored field for the command.
    assign wr_id     = wbs.wbs_sel_i[0] ? wbs.wbs_dat_i[4:0] : ctrl_id_q;
    assign wr_en     = wbs.wbs_sel_i[1] ? wbs.wbs_dat_i[8]   : ctrl_en_q;
    assign id_ok     = ({27'd0, wr_id} < NUM_PROJECTS);
    assign guard_eff = (guard_q == 8'd0) ? 8'd1 : guard_q;

    assign unused_bits = ^{wbs.wbs_dat_i[31:9], wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3:2]};

    always_comb begin
        rdata_mux = '0;
        case (offset)
            2'd0: begin
                rdata_mux[4:0] = ctrl_id_q;
                rdata_mux[8]   = ctrl_en_q;
            end
            2'd1: begin
                rdata_mux[4:0] = cur_id_q;
                rdata_mux[8]   = (state_q == S_ON);
                rdata_mux[9]   = (state_q == S_GUARD);
                rdata_mux[10]  = err_q;
            end
            2'd2:    rdata_mux[7:0] = guard_q;
            default: rdata_mux = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cur_id_d  = cur_id_q;
        pend_id_d = pend_id_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        sw_d      = 1'b0;
        if (ctrl_wr)
            err_d = wr_en & ~id_ok;
        case (state_q)
            S_OFF, S_ON: begin
                if (ctrl_wr && !wr_en) begin
                    state_d = S_OFF;
                end else if (ctrl_wr && id_ok &&
                             !(state_q == S_ON && wr_id == cur_id_q)) begin
                    state_d   = S_GUARD;
                    pend_id_d = wr_id;
                    cnt_d     = guard_eff;
                end
            end
            S_GUARD: begin
                cnt_d = cnt_q - 8'd1;
                if (ctrl_wr && !wr_en) begin
                    state_d = S_OFF;
                end else begin
                    // Retarget the in-flight switch without restarting the count.
                    if (ctrl_wr && id_ok)
                        pend_id_d = wr_id;
                    if (cnt_q == 8'd1) begin
                        state_d  = S_ON;
                        cur_id_d = pend_id_d;
                        sw_d     = 1'b1;
                    end
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_OFF;
            cur_id_q   <= '0;
            pend_id_q  <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            guard_q    <= DEFAULT_GUARD;
            ctrl_id_q  <= '0;
            ctrl_en_q  <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            active     <= '0;
            sw_q       <= 1'b0;
            switch_irq <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_id_q  <= cur_id_d;
            pend_id_q <= pend_id_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ack_q     <= acc;
            if (acc)
                rdata_q <= rdata_mux;
            if (ctrl_wr && wbs.wbs_sel_i[0])
                ctrl_id_q <= wbs.wbs_dat_i[4:0];
            if (ctrl_wr && wbs.wbs_sel_i[1])
                ctrl_en_q <= wbs.wbs_dat_i[8];
            if (guard_wr)
                guard_q <= wbs.wbs_dat_i[7:0];
            // Enable lags the state by one cycle so the old bit survives the ack cycle.
            active     <= (state_q == S_ON) ? (32'd1 << cur_id_q) : 32'd0;
            sw_q       <= sw_d;
            switch_irq <= sw_q;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = ack_q ? rdata_q : 32'd0;
endmodule

// File: tb/tb_project_select_ctrl.sv
// Bench for project_select_ctrl: two instances (32 and 4 projects) on one bus,
// checked every cycle against a timestamp-based model of the switching rules.
module tb_project_select_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, dat = 32'h0;
    logic [31:0] active0, active1;
    logic        irq0, irq1;

    project_select_ctrl_if bus0();
    project_select_ctrl_if bus1();

    assign bus0.wbs_stb_i = stb;  assign bus1.wbs_stb_i = stb;
    assign bus0.wbs_cyc_i = cyc;  assign bus1.wbs_cyc_i = cyc;
    assign bus0.wbs_we_i  = we;   assign bus1.wbs_we_i  = we;
    assign bus0.wbs_sel_i = sel;  assign bus1.wbs_sel_i = sel;
    assign bus0.wbs_adr_i = adr;  assign bus1.wbs_adr_i = adr;
    assign bus0.wbs_dat_i = dat;  assign bus1.wbs_dat_i = dat;

    project_select_ctrl #(.BASE_ADDR(BASE), .NUM_PROJECTS(32), .DEFAULT_GUARD(8'd4)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus0.slave), .active(active0), .switch_irq(irq0));
    project_select_ctrl #(.BASE_ADDR(BASE), .NUM_PROJECTS(4), .DEFAULT_GUARD(8'd4)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus1.slave), .active(active1), .switch_irq(irq1));

    always #5 clk = ~clk;

    // Model: mode 0 off, 1 switching, 2 on; a switch lands at an absolute edge number.
    int          m_mode[2], m_cur[2], m_pend[2], m_land[2], m_guard[2], m_cid[2];
    bit          m_cen[2], m_err[2], m_ack[2], m_sw[2], m_irq[2];
    logic [31:0] m_rd[2], m_act[2];
    int          edge_n = 0;
    int          vectors = 0, miscompares = 0;

    function automatic logic [31:0] readval(int k, logic [1:0] off);
        logic [31:0] r;
        int c;
        r = 32'd0;
        case (off)
            2'd0: begin c = m_cid[k]; r[4:0] = c[4:0]; r[8] = m_cen[k]; end
            2'd1: begin
                c = m_cur[k]; r[4:0] = c[4:0];
                r[8] = (m_mode[k] == 2); r[9] = (m_mode[k] == 1); r[10] = m_err[k];
            end
            2'd2: begin c = m_guard[k]; r[7:0] = c[7:0]; end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic void model_edge(int k);
        int np, id;
        bit hit, acc, en, ok, nsw, nirq;
        logic [31:0] nact;
        np = (k == 0) ? 32 : 4;
        if (rst) begin
            m_mode[k] = 0; m_cur[k] = 0; m_pend[k] = 0; m_land[k] = -1; m_guard[k] = 4;
            m_cid[k] = 0; m_cen[k] = 0; m_err[k] = 0; m_ack[k] = 0; m_sw[k] = 0;
            m_irq[k] = 0; m_rd[k] = 0; m_act[k] = 0;
            return;
        end
        hit  = stb && cyc && (adr[31:4] == BASE[31:4]);
        acc  = hit && !m_ack[k];
        nact = (m_mode[k] == 2) ? (32'd1 << m_cur[k]) : 32'd0;
        nirq = m_sw[k];
        nsw  = 0;
        if (acc) m_rd[k] = readval(k, adr[3:2]);
        if (acc && we && adr[3:2] == 2'd0 && (sel[0] || sel[1])) begin
            id = sel[0] ? int'(dat[4:0]) : m_cid[k];
            en = sel[1] ? dat[8] : m_cen[k];
            ok = id < np;
            m_cid[k] = id; m_cen[k] = en;
            m_err[k] = en && !ok;
            if (!en) m_mode[k] = 0;
            else if (ok) begin
                if (m_mode[k] == 1) m_pend[k] = id;
                else if (!(m_mode[k] == 2 && id == m_cur[k])) begin
                    m_mode[k] = 1; m_pend[k] = id;
                    m_land[k] = edge_n + ((m_guard[k] == 0) ? 1 : m_guard[k]);
                end
            end
        end
        if (m_mode[k] == 1 && edge_n == m_land[k]) begin
            m_mode[k] = 2; m_cur[k] = m_pend[k]; nsw = 1;
        end
        if (acc && we && adr[3:2] == 2'd2 && sel[0]) m_guard[k] = int'(dat[7:0]);
        m_ack[k] = acc; m_act[k] = nact; m_irq[k] = nirq; m_sw[k] = nsw;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, edge_n, got, exp);
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] act, dout;
            logic ack, irq;
            act  = (k == 0) ? active0 : active1;
            dout = (k == 0) ? bus0.wbs_dat_o : bus1.wbs_dat_o;
            ack  = (k == 0) ? bus0.wbs_ack_o : bus1.wbs_ack_o;
            irq  = (k == 0) ? irq0 : irq1;
            check("ack", k, {31'd0, ack}, {31'd0, m_ack[k]});
            check("dat_o", k, dout, m_ack[k] ? m_rd[k] : 32'd0);
            check("active", k, act, m_act[k]);
            check("irq", k, {31'd0, irq}, {31'd0, m_irq[k]});
            check("onehot0", k, {31'd0, $onehot0(act)}, 32'd1);
        end
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        edge_n++;
        @(negedge clk);
        compare();
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input bit exp_ack,
                        output logic [31:0] r0, output logic [31:0] r1, output int ae);
        stb = 1; cyc = 1; we = w; adr = a; dat = d; sel = 4'hF;
        ae = -1; r0 = 32'd0; r1 = 32'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus0.wbs_ack_o === 1'b1) begin
                r0 = bus0.wbs_dat_o; r1 = bus1.wbs_dat_o; ae = edge_n;
                break;
            end
        end
        stb = 0; cyc = 0; we = 0;
        check("ack_seen", 0, {31'd0, ae >= 0}, {31'd0, exp_ack});
    endtask

    initial begin
        logic [31:0] r0, r1;
        int a;
        // Reset
        rst = 1; tick(); tick(); rst = 0;
        check("rst_active", 0, active0, 32'd0);
        xfer(0, BASE + 32'h4, 0, 1, r0, r1, a);
        check("rst_status", 0, r0, 32'd0);
        xfer(0, BASE + 32'h8, 0, 1, r0, r1, a);
        check("rst_guard", 0, r0, 32'd4);

        // Switch to project 3 with the default guard of 4
        xfer(1, BASE, 32'h103, 1, r0, r1, a);
        for (int j = 1; j <= 4; j++) begin tick(); check("guard_gap", 0, active0, 32'd0); end
        tick(); check("first_on", 0, active0, 32'h8); check("first_irq", 0, {31'd0, irq0}, 32'd1);
        tick(); check("irq_pulse", 0, {31'd0, irq0}, 32'd0);

        // Guard 0 behaves as a single off cycle
        xfer(1, BASE + 32'h8, 32'h0, 1, r0, r1, a);
        xfer(1, BASE, 32'h101, 1, r0, r1, a);
        tick(); check("g0_gap", 0, active0, 32'd0);
        tick(); check("g0_on", 0, active0, 32'h2);
        xfer(0, BASE + 32'h4, 0, 1, r0, r1, a);
        check("g0_status", 0, r0, 32'h101);

        // Retarget mid-guard: landing time follows the first request
        xfer(1, BASE + 32'h8, 32'h4, 1, r0, r1, a);
        xfer(1, BASE, 32'h103, 1, r0, r1, a);
        tick();
        xfer(1, BASE, 32'h107, 1, r0, r1, r0);
        while (edge_n < a + 5) begin
            tick();
            if (edge_n < a + 5) check("retarget_gap", 0, active0, 32'd0);
        end
        check("retarget_on", 0, active0, 32'h80);
        check("retarget_np4", 1, active1, 32'h8);

        // Disable, then reset in the middle of a guard interval
        xfer(1, BASE, 32'h000, 1, r0, r1, a);
        tick(); check("off_active", 0, active0, 32'd0);
        xfer(0, BASE + 32'h4, 0, 1, r0, r1, a);
        check("off_status", 0, r0, 32'h007);
        xfer(1, BASE, 32'h105, 1, r0, r1, a);
        tick(); tick();
        rst = 1; tick(); rst = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            check("abort_irq", 0, {31'd0, irq0}, 32'd0);
            check("abort_active", 0, active0, 32'd0);
        end

        // Out-of-range id on the 4-project instance
        xfer(1, BASE, 32'h105, 1, r0, r1, a);
        xfer(0, BASE + 32'h4, 0, 1, r0, r1, a);
        check("err_set", 1, r1, 32'h400);
        check("err_active", 1, active1, 32'd0);
        xfer(1, BASE, 32'h102, 1, r0, r1, a);
        while (edge_n < a + 5) tick();
        check("err_switch", 1, active1, 32'h4);
        xfer(0, BASE + 32'h4, 0, 1, r0, r1, a);
        check("err_clear", 1, r1, 32'h102);

        // Reserved slot and decode edges
        xfer(0, BASE + 32'hC, 0, 1, r0, r1, a);
        check("rsvd_read", 0, r0, 32'd0);
        xfer(0, BASE + 32'h10, 0, 0, r0, r1, a);
        xfer(1, 32'h2000_0000, 32'h105, 0, r0, r1, a);

        // Randomized bus traffic, resets included
        for (int n = 0; n < 3000; n++) begin
            int off;
            rst = ($urandom_range(0, 149) == 0);
            stb = ($urandom_range(0, 1) == 1);
            cyc = stb ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
            we  = ($urandom_range(0, 2) != 0);
            off = $urandom_range(0, 3);
            case ($urandom_range(0, 9))
                0:       adr = BASE + 32'h10 + 32'(off * 4);
                1:       adr = $urandom;
                default: adr = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            endcase
            sel = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            if (off == 2) dat = 32'($urandom_range(0, 6)) | ($urandom & 32'hFFFF_FF00);
            else          dat = ($urandom & 32'hFFFF_FE00) | ($urandom & 32'h11F) |
                                (($urandom_range(0, 3) != 0) ? 32'h100 : 32'h0);
            tick();
        end
        rst = 0; stb = 0; cyc = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
